// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : register-file write-back arbiter (ALU priority, MDU FIFO)
//                 with per-register pending scoreboard for decode stalls.
// Revision      : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [31:0]                  alu_data,
    input  logic                         mdu_issue,
    input  logic [4:0]                   issue_rd,
    input  logic                         mdu_valid,
    output logic                         mdu_ready,
    input  logic [4:0]                   mdu_rd,
    input  logic [31:0]                  mdu_data,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         RegWrite,
    output logic [4:0]                   WriteReg,
    output logic [31:0]                  WriteData,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [4:0]      r_fifo_rd   [DEPTH];
    logic [31:0]     r_fifo_data [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_pending;

    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [31:0]     w_head_data;
    logic [31:0]     w_pending_nxt;

    assign mdu_ready   = (r_count != c_CW'(DEPTH));
    assign w_push      = mdu_valid && mdu_ready;
    // The ALU path is never stalled, so the FIFO head only drains on idle ALU cycles.
    assign w_pop       = !alu_valid && (r_count != '0);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    assign rs1_busy    = (rs1 != 5'd0) && r_pending[rs1];
    assign rs2_busy    = (rs2 != 5'd0) && r_pending[rs2];
    assign fifo_count  = r_count;

    // Clear first so that a same-cycle issue to the retiring register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (mdu_issue) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mdu_rd;
            r_fifo_data[r_wptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= 5'd0;
            WriteData <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end

            if (alu_valid) begin
                RegWrite  <= (alu_rd != 5'd0);
                WriteReg  <= alu_rd;
                WriteData <= alu_data;
            end else if (w_pop) begin
                RegWrite  <= (w_head_rd != 5'd0);
                WriteReg  <= w_head_rd;
                WriteData <= w_head_data;
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : randomized + directed bench against a queue-based model.
// Revision         : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mdu_issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    rf_wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_issue(mdu_issue), .issue_rd(issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of {rd,data} in acceptance order, pending bit per register.
    logic [36:0] m_q[$];
    bit   [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    // Entered and left at a falling edge.
    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit iss, input logic [4:0] ird,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] q1, input logic [4:0] q2);
        bit         ready;
        logic [36:0] e;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mdu_issue = iss; issue_rd = ird;
        mdu_valid = mv;  mdu_rd = mrd;  mdu_data = mdat;
        rs1 = q1; rs2 = q2;
        #1;
        ready = (m_q.size() != DEPTH);
        chk("mdu_ready", 32'(mdu_ready), 32'(ready));
        chk("rs1_busy", 32'(rs1_busy), 32'(m_busy(q1)));
        chk("rs2_busy", 32'(rs2_busy), 32'(m_busy(q2)));
        @(posedge clk);
        if (av) begin
            m_we = (ard != 0); m_wr = ard; m_wd = adat;
        end else if (m_q.size() != 0) begin
            e = m_q.pop_front();
            m_wr = e[36:32]; m_wd = e[31:0]; m_we = (m_wr != 0);
            m_pend[m_wr] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (mv && ready) m_q.push_back({mrd, mdat});
        if (iss && ird != 0) m_pend[ird] = 1'b1;
        m_pend[0] = 1'b0;
        #1;
        chk("RegWrite", 32'(RegWrite), 32'(m_we));
        chk("WriteReg", 32'(WriteReg), 32'(m_wr));
        chk("WriteData", WriteData, m_wd);
        chk("fifo_count", 32'(fifo_count), m_q.size());
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] q1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    // Assert reset between edges and check that it acts without a clock.
    task automatic do_reset();
        alu_valid = 0; mdu_issue = 0; mdu_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(mdu_ready), 1);
        m_q.delete(); m_pend = '0; m_we = 0; m_wr = 0; m_wd = 0;
        @(posedge clk); #1;
        chk("rst_WriteReg", 32'(WriteReg), 0);
        chk("rst_WriteData", WriteData, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_q.delete(); m_pend = '0; m_we = 0; m_wr = 0; m_wd = 0;
        @(negedge clk);
        #1;
        chk("init_RegWrite", 32'(RegWrite), 0);
        chk("init_count", 32'(fifo_count), 0);
        chk("init_ready", 32'(mdu_ready), 1);
        chk("init_busy", 32'(rs1_busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU priority over a queued MDU result.
        cyc(1, 1, 32'h1, 0, 0, 1, 6, 32'h22, 0, 0);
        cyc(1, 5, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("prio_x6", 32'(WriteReg), 6);

        // Fill under ALU pressure, fifth offer refused, drain, then wrap.
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(1, 5'(i + 1), 32'(i), 0, 0, 1, 5'(10 + i), 32'hA0 + 32'(i), 0, 0);
        chk("full_ready", 32'(mdu_ready), 0);
        for (int i = 0; i < DEPTH; i++) idle(0);
        for (int i = 0; i < 3; i++)
            cyc(1, 3, 32'h3, 0, 0, 1, 5'(20 + i), 32'hB0 + 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) idle(0);

        // Scoreboard: issue x9, result later, same-cycle reissue on retire.
        cyc(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
        cyc(1, 2, 32'h2, 0, 0, 1, 9, 32'h99, 9, 9);
        cyc(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
        chk("reissue_busy", 32'(rs1_busy), 1);
        cyc(0, 0, 0, 0, 0, 1, 9, 32'h98, 9, 0);
        idle(9);
        chk("clear_busy", 32'(rs1_busy), 0);

        // x0 suppression on both paths and on issue.
        cyc(1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 32'h55, 0, 0);
        idle(0);
        chk("x0_mdu_we", 32'(RegWrite), 0);

        // Simultaneous push and pop at count 2.
        cyc(1, 4, 32'h4, 0, 0, 1, 12, 32'hC1, 0, 0);
        cyc(1, 4, 32'h4, 0, 0, 1, 13, 32'hC2, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 14, 32'hC3, 0, 0);
        chk("pp_count", 32'(fifo_count), 2);
        for (int i = 0; i < 3; i++) idle(0);

        // Reset with three entries queued; nothing may retire afterwards.
        for (int i = 0; i < 3; i++)
            cyc(1, 7, 32'h7, 1, 5'(15 + i), 1, 5'(15 + i), 32'hD0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) idle(15);

        // Randomized phases alternating heavy and light ALU traffic.
        for (int ph = 0; ph < 20; ph++) begin
            int alu_pct = (ph % 2 == 0) ? 85 : 15;
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            end
            if (ph % 7 == 6) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-register scoreboard that drives the single write port of the register file (RegWrite/WriteReg/WriteData). It merges results from the non-stallable ALU pipeline and the long-latency multiply/divide unit (MDU) into one registered write stream. ALU results take priority; MDU results are buffered in a small FIFO. A per-register pending scoreboard tells the decode stage which source registers still await an MDU result.

## Interface
- DEPTH, 4, MDU result FIFO entries; power of two, >= 2
- clk  in  1  pipeline clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; never stalled
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mdu_issue  in  1  MDU operation issued this cycle; marks issue_rd pending
- issue_rd  in  5  destination of issued MDU operation
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; a transfer occurs when mdu_valid && mdu_ready
- mdu_rd  in  5  MDU result destination
- mdu_data  in  32  MDU result
- rs1, rs2  in  5 each  decode-stage source addresses for the busy query
- rs1_busy, rs2_busy  out  1 each  source pending (combinational)
- RegWrite  out  1  register-file write enable, registered
- WriteReg  out  5  register-file write address, registered
- WriteData  out  32  register-file write data, registered
- fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Output register: on each posedge exactly one of three cases applies.
  - If alu_valid, load the ALU result.
  - Else, if the FIFO is non-empty, pop the head and load it.
  - Else, load RegWrite=0. WriteReg and WriteData hold their values.
- RegWrite is loaded as 0 whenever the selected destination is 0. The entry or result is still consumed. x0 is never written.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - mdu_ready = (count != DEPTH). It is not dependent on mdu_valid.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
  - A push is never accepted when full, even if a pop occurs in the same cycle.
- Ordering: MDU results retire in acceptance order. An ALU result presented in the same cycle as a non-empty FIFO wins. The FIFO head waits.
- Scoreboard (32 pending bits):
  - On mdu_issue with issue_rd != 0, set pending[issue_rd].
  - Clear pending[r] on the edge where a FIFO entry with rd r is loaded into the output register.
  - If a set and a clear target the same register in the same cycle, the set wins.
  - ALU writes never touch pending bits.
  - pending[0] is constantly 0.
- Busy query: rsN_busy = (rsN != 0) && pending[rsN]. Upstream stalls on busy, which prevents WAW between the ALU and the MDU.
- Reset: the FIFO is emptied, all pending bits clear, and RegWrite, WriteReg, WriteData and fifo_count are all 0. mdu_ready = 1 and rs1_busy = rs2_busy = 0 immediately.
- A reset asserted mid-operation discards all buffered MDU results and pending state without producing any write.

## Timing
- ALU latency:
  - Result presented in cycle N; RegWrite/WriteReg/WriteData are valid throughout cycle N+1.
  - The register file captures the write on the falling edge inside N+1.
- MDU latency, minimum:
  - Accepted in cycle N; in the FIFO from N+1.
  - If there is no ALU result in N+1, it drives the write port in N+2.
  - Each cycle of ALU activity adds one cycle of delay.
- Pending clears on the same edge the write port loads the entry. rsN_busy drops in the cycle the register-file write occurs, and decode reads the new value after the falling edge.
- Back-to-back ALU results for DEPTH+k cycles starve the FIFO. The FIFO fills after DEPTH accepts, then mdu_ready stays 0 until the first idle ALU cycle.
- All outputs except rsN_busy and mdu_ready are registered. mdu_ready depends only on the registered count.

## Test plan
- Reset behaviour: assert rst mid-stream with 3 entries queued. Required: fifo_count=0, RegWrite=0 asynchronously, mdu_ready=1, and no write for any queued entry after release.
- ALU priority: alu_valid with rd=5 and data 0x11 in cycle N, while the FIFO holds rd=6 with data 0x22. Required: cycle N+1 writes x5=0x11; cycle N+2 writes x6=0x22.
- FIFO full and wrap:
  - Hold alu_valid and push DEPTH MDU results. Required: mdu_ready=0 with count=4, and a 5th offer is not accepted.
  - Release the ALU. Required: the entries drain in order on 4 consecutive writes.
  - Push 3 more. Required: the pointers wrap and order is preserved.
- Scoreboard: mdu_issue with rd=9, then query rs1=9. Required: busy=1 until the cycle x9 is written, and 0 from that cycle.
  - Same-cycle clear of x9 with a new issue to x9. Required: busy stays 1.
- x0 suppression:
  - ALU rd=0 with data 0xFFFF_FFFF. Required: RegWrite=0.
  - MDU result with rd=0. Required: it is consumed (count decrements) with RegWrite=0.
  - issue_rd=0. Required: rs1=0 never reports busy.
- Simultaneous push and pop at count=2. Required: count stays 2 and the data order is correct.
